// File: rtl/bank_timing_tracker_pkg.sv
// Shared types and defaults for the per-bank DDR3 timing tracker.
//   sch_cmd_t      : 4-bit scheduler command encoding (10..15 are undefined)
//   recode_state_t : 3-bit code naming the window held by the main counter
//   DEF_T_*        : default same-bank timings in controller clock cycles
//   max_cnt        : unsigned maximum used when merging timing windows
package bank_timing_tracker_pkg;

  localparam int DEF_T_RCD = 11;  // ACT -> RD/WR
  localparam int DEF_T_RP  = 11;  // PRE -> ACT/REF
  localparam int DEF_T_RAS = 28;  // ACT -> PRE
  localparam int DEF_T_RTP = 6;   // RD  -> PRE
  localparam int DEF_T_WTP = 24;  // WR  -> PRE (WL + BL/2 + tWR)
  localparam int DEF_T_CCD = 4;   // RD/WR -> RD/WR
  localparam int DEF_T_RFC = 88;  // REF -> ACT/REF
  localparam int DEF_CNT_W = 8;

  typedef enum logic [3:0] {
    CMD_NOP       = 4'd0,
    CMD_ACTIVE    = 4'd1,
    CMD_READ      = 4'd2,
    CMD_WRITE     = 4'd3,
    CMD_RDA       = 4'd4,
    CMD_WRA       = 4'd5,
    CMD_PRECHARGE = 4'd6,
    CMD_REFRESH   = 4'd7,
    CMD_POWER_D   = 4'd8,
    CMD_POWER_U   = 4'd9
  } sch_cmd_t;

  typedef enum logic [2:0] {
    CODE_IDLE                 = 3'd0,
    CODE_ACTIVE_TO_READ_WRITE = 3'd1,
    CODE_READ_TO_PRECHARGE    = 3'd2,
    CODE_WRITE_TO_PRECHARGE   = 3'd3,
    CODE_READ_TO_ACTIVE       = 3'd4,
    CODE_WRITE_TO_ACTIVE      = 3'd5,
    CODE_PRECHARGE_TO_ACTIVE  = 3'd6,
    CODE_PRECHARGE_TO_REFRESH = 3'd7
  } recode_state_t;

  function automatic int unsigned max_cnt(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bank_timing_tracker_counter.sv
// Saturating down counter used for each timing window.
//   clk_i, rst_ni : clock, synchronous active-low reset (clears to 0)
//   load_i        : replace the count with load_val_i this cycle
//   load_val_i    : value to load
//   cnt_o         : current count
//   zero_o        : count has expired
// Without a load the count drops by one per cycle and holds at zero.
module timing_down_counter
  import bank_timing_tracker_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] cnt_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/bank_timing_tracker.sv
// Per-bank timing tracker: follows every command issued to one bank, keeps
// the open/closed row state and the same-bank timing windows, and tells the
// bank controller which command classes are legal this cycle.
//   clk_i, rst_ni   : clock, synchronous active-low reset
//   cmd_valid_i     : a command was issued to this bank this cycle
//   cmd_i           : sch_cmd_t encoding of that command
//   act_ok_o        : ACTIVE legal this cycle
//   rw_ok_o         : READ/WRITE/RDA/WRA legal this cycle
//   pre_ok_o        : PRECHARGE legal this cycle
//   ref_ok_o        : REFRESH legal this cycle
//   row_open_o      : a row is active
//   timing_state_o  : recode_state_t of the main window
//   protocol_err_o  : one-cycle pulse after an illegal/undefined command
// Loading N-1 on the issue cycle t makes the dependent command legal at t+N.
// Every T_* must satisfy 1 <= T_* < 2**CNT_W.
module bank_timing_tracker
  import bank_timing_tracker_pkg::*;
#(
  parameter int T_RCD = DEF_T_RCD,
  parameter int T_RP  = DEF_T_RP,
  parameter int T_RAS = DEF_T_RAS,
  parameter int T_RTP = DEF_T_RTP,
  parameter int T_WTP = DEF_T_WTP,
  parameter int T_CCD = DEF_T_CCD,
  parameter int T_RFC = DEF_T_RFC,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cmd_valid_i,
  input  logic [3:0] cmd_i,
  output logic       act_ok_o,
  output logic       rw_ok_o,
  output logic       pre_ok_o,
  output logic       ref_ok_o,
  output logic       row_open_o,
  output logic [2:0] timing_state_o,
  output logic       protocol_err_o
);

  localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP  - 1);
  localparam logic [CNT_W-1:0] LD_RAS = CNT_W'(T_RAS - 1);
  localparam logic [CNT_W-1:0] LD_RTP = CNT_W'(T_RTP - 1);
  localparam logic [CNT_W-1:0] LD_WTP = CNT_W'(T_WTP - 1);
  localparam logic [CNT_W-1:0] LD_CCD = CNT_W'(T_CCD - 1);
  localparam logic [CNT_W-1:0] LD_RFC = CNT_W'(T_RFC - 1);
  localparam logic [CNT_W:0]   SUM_RP = (CNT_W+1)'(T_RP);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  sch_cmd_t      cmd;
  recode_state_t state_q, state_d;
  logic          row_open_q, row_open_d;
  logic          err_q, err_d;

  logic [CNT_W-1:0] main_cnt, ras_cnt, ccd_cnt;
  logic             main_zero, ras_zero, ccd_zero;
  logic             main_ld, ras_ld, ccd_ld;
  logic [CNT_W-1:0] main_ld_val;
  recode_state_t    main_ld_st;

  logic act_ok, rw_ok, pre_ok;

  // Auto-precharge timing: the implicit PRE fires once both tRAS and the
  // read/write recovery have run out, then tRP follows. ras_nxt is the tRAS
  // remainder as seen from the cycle after issue, which is where the new
  // main window starts counting.
  logic [CNT_W-1:0] ras_nxt, rda_base, wra_base, rda_ld, wra_ld;
  logic [CNT_W:0]   rda_sum, wra_sum;

  assign cmd     = sch_cmd_t'(cmd_i);
  assign ras_nxt = ras_zero ? '0 : ras_cnt - 1'b1;

  assign rda_base = CNT_W'(max_cnt(32'(ras_nxt), 32'(LD_RTP)));
  assign wra_base = CNT_W'(max_cnt(32'(ras_nxt), 32'(LD_WTP)));
  assign rda_sum  = {1'b0, rda_base} + SUM_RP;
  assign wra_sum  = {1'b0, wra_base} + SUM_RP;
  assign rda_ld   = rda_sum[CNT_W] ? '1 : rda_sum[CNT_W-1:0];
  assign wra_ld   = wra_sum[CNT_W] ? '1 : wra_sum[CNT_W-1:0];

  timing_down_counter #(.W(CNT_W)) u_main (
    .clk_i, .rst_ni, .load_i(main_ld), .load_val_i(main_ld_val),
    .cnt_o(main_cnt), .zero_o(main_zero)
  );

  timing_down_counter #(.W(CNT_W)) u_ras (
    .clk_i, .rst_ni, .load_i(ras_ld), .load_val_i(LD_RAS),
    .cnt_o(ras_cnt), .zero_o(ras_zero)
  );

  timing_down_counter #(.W(CNT_W)) u_ccd (
    .clk_i, .rst_ni, .load_i(ccd_ld), .load_val_i(LD_CCD),
    .cnt_o(ccd_cnt), .zero_o(ccd_zero)
  );

  // Permissions come straight from registered state.
  assign act_ok = !row_open_q && main_zero;
  assign rw_ok  = row_open_q && (state_q != CODE_ACTIVE_TO_READ_WRITE || main_zero) && ccd_zero;
  assign pre_ok = row_open_q && ras_zero && (main_zero || state_q == CODE_IDLE);

  always_comb begin
    row_open_d  = row_open_q;
    state_d     = state_q;
    main_ld     = 1'b0;
    main_ld_val = '0;
    main_ld_st  = CODE_IDLE;
    ras_ld      = 1'b0;
    ccd_ld      = 1'b0;
    err_d       = 1'b0;

    if (cmd_valid_i) begin
      case (cmd)
        CMD_NOP, CMD_POWER_D, CMD_POWER_U: begin end
        CMD_ACTIVE: begin
          if (act_ok) begin
            row_open_d  = 1'b1;
            main_ld     = 1'b1;
            main_ld_val = LD_RCD;
            main_ld_st  = CODE_ACTIVE_TO_READ_WRITE;
            ras_ld      = 1'b1;
          end else err_d = 1'b1;
        end
        // RD/WR only ever extend the main window: a short read window must
        // not cut a pending write-recovery window. Equal values go to the
        // newer command.
        CMD_READ: begin
          if (rw_ok) begin
            ccd_ld = 1'b1;
            if (LD_RTP >= main_cnt) begin
              main_ld     = 1'b1;
              main_ld_val = LD_RTP;
              main_ld_st  = CODE_READ_TO_PRECHARGE;
            end
          end else err_d = 1'b1;
        end
        CMD_WRITE: begin
          if (rw_ok) begin
            ccd_ld = 1'b1;
            if (LD_WTP >= main_cnt) begin
              main_ld     = 1'b1;
              main_ld_val = LD_WTP;
              main_ld_st  = CODE_WRITE_TO_PRECHARGE;
            end
          end else err_d = 1'b1;
        end
        CMD_RDA: begin
          if (rw_ok) begin
            row_open_d  = 1'b0;
            main_ld     = 1'b1;
            main_ld_val = rda_ld;
            main_ld_st  = CODE_READ_TO_ACTIVE;
          end else err_d = 1'b1;
        end
        CMD_WRA: begin
          if (rw_ok) begin
            row_open_d  = 1'b0;
            main_ld     = 1'b1;
            main_ld_val = wra_ld;
            main_ld_st  = CODE_WRITE_TO_ACTIVE;
          end else err_d = 1'b1;
        end
        CMD_PRECHARGE: begin
          if (pre_ok) begin
            row_open_d  = 1'b0;
            main_ld     = 1'b1;
            main_ld_val = LD_RP;
            main_ld_st  = CODE_PRECHARGE_TO_ACTIVE;
          end else err_d = 1'b1;
        end
        CMD_REFRESH: begin
          if (act_ok) begin
            main_ld     = 1'b1;
            main_ld_val = LD_RFC;
            main_ld_st  = CODE_PRECHARGE_TO_REFRESH;
          end else err_d = 1'b1;
        end
        default: err_d = 1'b1;
      endcase
    end

    // The state code names whatever window the main counter holds, so it
    // drops to IDLE exactly when that window expires.
    if (main_ld)                state_d = (main_ld_val == '0) ? CODE_IDLE : main_ld_st;
    else if (main_cnt == ONE)   state_d = CODE_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      row_open_q <= 1'b0;
      state_q    <= CODE_IDLE;
      err_q      <= 1'b0;
    end else begin
      row_open_q <= row_open_d;
      state_q    <= state_d;
      err_q      <= err_d;
    end
  end

  assign act_ok_o       = act_ok;
  assign ref_ok_o       = act_ok;
  assign rw_ok_o        = rw_ok;
  assign pre_ok_o       = pre_ok;
  assign row_open_o     = row_open_q;
  assign timing_state_o = state_q;
  assign protocol_err_o = err_q;

endmodule

// File: tb/tb_bank_timing_tracker.sv
module tb_bank_timing_tracker;
  import bank_timing_tracker_pkg::*;

  localparam int T_RCD = DEF_T_RCD;
  localparam int T_RP  = DEF_T_RP;
  localparam int T_RAS = DEF_T_RAS;
  localparam int T_RTP = DEF_T_RTP;
  localparam int T_WTP = DEF_T_WTP;
  localparam int T_CCD = DEF_T_CCD;
  localparam int T_RFC = DEF_T_RFC;

  logic       clk = 1'b0;
  logic       rst_ni, cmd_valid_i;
  logic [3:0] cmd_i;
  logic       act_ok_o, rw_ok_o, pre_ok_o, ref_ok_o, row_open_o, protocol_err_o;
  logic [2:0] timing_state_o;

  bank_timing_tracker dut (
    .clk_i(clk), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid_i), .cmd_i(cmd_i),
    .act_ok_o(act_ok_o), .rw_ok_o(rw_ok_o), .pre_ok_o(pre_ok_o), .ref_ok_o(ref_ok_o),
    .row_open_o(row_open_o), .timing_state_o(timing_state_o), .protocol_err_o(protocol_err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: absolute cycle numbers at which each constraint ends.
  bit            m_open;
  int            m_main_end, m_ras_end, m_ccd_end;
  recode_state_t m_st;
  bit            m_err;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic recode_state_t m_state();
    return (cyc < m_main_end) ? m_st : CODE_IDLE;
  endfunction
  function automatic bit m_act();
    return !m_open && cyc >= m_main_end;
  endfunction
  function automatic bit m_rw();
    return m_open && m_state() != CODE_ACTIVE_TO_READ_WRITE && cyc >= m_ccd_end;
  endfunction
  function automatic bit m_pre();
    return m_open && cyc >= m_ras_end && cyc >= m_main_end;
  endfunction

  task automatic check_model();
    chk("act_ok",   8'(act_ok_o),       8'(m_act()));
    chk("ref_ok",   8'(ref_ok_o),       8'(m_act()));
    chk("rw_ok",    8'(rw_ok_o),        8'(m_rw()));
    chk("pre_ok",   8'(pre_ok_o),       8'(m_pre()));
    chk("row_open", 8'(row_open_o),     8'(m_open));
    chk("state",    8'(timing_state_o), 8'(m_state()));
    chk("perr",     8'(protocol_err_o), 8'(m_err));
  endtask

  task automatic model_apply(input bit rst, input bit v, input logic [3:0] c);
    int e;
    bit ill;
    ill = 1'b0;
    if (rst) begin
      m_open = 0; m_main_end = 0; m_ras_end = 0; m_ccd_end = 0; m_st = CODE_IDLE; m_err = 0;
      return;
    end
    if (v) begin
      case (c)
        CMD_NOP, CMD_POWER_D, CMD_POWER_U: begin end
        CMD_ACTIVE: begin
          if (m_act()) begin
            m_open = 1; m_main_end = cyc + T_RCD; m_st = CODE_ACTIVE_TO_READ_WRITE;
            m_ras_end = cyc + T_RAS;
          end else ill = 1;
        end
        CMD_READ, CMD_WRITE: begin
          if (m_rw()) begin
            m_ccd_end = cyc + T_CCD;
            e = cyc + ((c == CMD_READ) ? T_RTP : T_WTP);
            if (e > m_main_end) begin
              m_main_end = e;
              m_st = (c == CMD_READ) ? CODE_READ_TO_PRECHARGE : CODE_WRITE_TO_PRECHARGE;
            end
          end else ill = 1;
        end
        CMD_RDA, CMD_WRA: begin
          if (m_rw()) begin
            e = cyc + ((c == CMD_RDA) ? T_RTP : T_WTP);
            if (m_ras_end > e) e = m_ras_end;
            m_open = 0; m_main_end = e + T_RP;
            m_st = (c == CMD_RDA) ? CODE_READ_TO_ACTIVE : CODE_WRITE_TO_ACTIVE;
          end else ill = 1;
        end
        CMD_PRECHARGE: begin
          if (m_pre()) begin
            m_open = 0; m_main_end = cyc + T_RP; m_st = CODE_PRECHARGE_TO_ACTIVE;
          end else ill = 1;
        end
        CMD_REFRESH: begin
          if (m_act()) begin
            m_main_end = cyc + T_RFC; m_st = CODE_PRECHARGE_TO_REFRESH;
          end else ill = 1;
        end
        default: ill = 1;
      endcase
    end
    m_err = ill;
  endtask

  // Drive one cycle, advance the model, then check at the next falling edge.
  task automatic step(input bit rst, input bit v, input logic [3:0] c);
    rst_ni = !rst; cmd_valid_i = v; cmd_i = c;
    model_apply(rst, v, c);
    cyc++;
    @(negedge clk);
    check_model();
  endtask

  task automatic reset_bank();
    step(1'b1, 1'b0, CMD_NOP);
  endtask

  function automatic logic [3:0] pick_legal();
    logic [3:0] cand[$];
    cand.push_back(CMD_NOP);
    cand.push_back(CMD_POWER_D);
    if (m_act()) begin
      cand.push_back(CMD_ACTIVE);
      cand.push_back(CMD_ACTIVE);
      if ($urandom_range(0, 7) == 0) cand.push_back(CMD_REFRESH);
    end
    if (m_rw()) begin
      cand.push_back(CMD_READ);  cand.push_back(CMD_WRITE);
      cand.push_back(CMD_READ);  cand.push_back(CMD_WRITE);
      cand.push_back(CMD_RDA);   cand.push_back(CMD_WRA);
    end
    if (m_pre()) cand.push_back(CMD_PRECHARGE);
    return cand[$urandom_range(0, cand.size() - 1)];
  endfunction

  initial begin
    m_open = 0; m_main_end = 0; m_ras_end = 0; m_ccd_end = 0; m_st = CODE_IDLE; m_err = 0;
    rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_i = CMD_NOP;
    @(negedge clk);
    reset_bank();
    chk("rst_act",   8'(act_ok_o), 8'd1);
    chk("rst_ref",   8'(ref_ok_o), 8'd1);
    chk("rst_rw",    8'(rw_ok_o),  8'd0);
    chk("rst_pre",   8'(pre_ok_o), 8'd0);
    chk("rst_state", 8'(timing_state_o), 8'(CODE_IDLE));

    // ACT@0: rw_ok at 11, pre_ok at 28.
    for (int k = 0; k < 30; k++) begin
      if (k == 10) begin chk("a_rw10", 8'(rw_ok_o), 8'd0); chk("a_st10", 8'(timing_state_o), 8'(CODE_ACTIVE_TO_READ_WRITE)); end
      if (k == 11) begin chk("a_rw11", 8'(rw_ok_o), 8'd1); chk("a_st11", 8'(timing_state_o), 8'(CODE_IDLE)); end
      if (k == 27) chk("a_pre27", 8'(pre_ok_o), 8'd0);
      if (k == 28) chk("a_pre28", 8'(pre_ok_o), 8'd1);
      step(1'b0, k == 0, CMD_ACTIVE);
    end

    // ACT@0, READ@11, READ@15.
    reset_bank();
    for (int k = 0; k < 30; k++) begin
      logic [3:0] c;
      c = (k == 0) ? CMD_ACTIVE : CMD_READ;
      if (k == 12) chk("rr_rw12", 8'(rw_ok_o), 8'd0);
      if (k == 14) chk("rr_rw14", 8'(rw_ok_o), 8'd0);
      if (k == 15) chk("rr_rw15", 8'(rw_ok_o), 8'd1);
      if (k == 20) chk("rr_st20", 8'(timing_state_o), 8'(CODE_READ_TO_PRECHARGE));
      if (k == 21) begin chk("rr_st21", 8'(timing_state_o), 8'(CODE_IDLE)); chk("rr_pre21", 8'(pre_ok_o), 8'd0); end
      if (k == 27) chk("rr_pre27", 8'(pre_ok_o), 8'd0);
      if (k == 28) chk("rr_pre28", 8'(pre_ok_o), 8'd1);
      step(1'b0, k == 0 || k == 11 || k == 15, c);
    end

    // ACT@0, WRITE@11, READ@15: write recovery is not shortened.
    reset_bank();
    for (int k = 0; k < 37; k++) begin
      logic [3:0] c;
      c = (k == 0) ? CMD_ACTIVE : (k == 11) ? CMD_WRITE : CMD_READ;
      if (k == 16) chk("wr_st16", 8'(timing_state_o), 8'(CODE_WRITE_TO_PRECHARGE));
      if (k == 21) chk("wr_pre21", 8'(pre_ok_o), 8'd0);
      if (k == 34) chk("wr_pre34", 8'(pre_ok_o), 8'd0);
      if (k == 35) chk("wr_pre35", 8'(pre_ok_o), 8'd1);
      step(1'b0, k == 0 || k == 11 || k == 15, c);
    end

    // ACT@0, RDA@11: ACT legal again at 39.
    reset_bank();
    for (int k = 0; k < 41; k++) begin
      if (k == 12) begin chk("rda_open12", 8'(row_open_o), 8'd0); chk("rda_st12", 8'(timing_state_o), 8'(CODE_READ_TO_ACTIVE)); end
      if (k == 38) chk("rda_act38", 8'(act_ok_o), 8'd0);
      if (k == 39) chk("rda_act39", 8'(act_ok_o), 8'd1);
      step(1'b0, k == 0 || k == 11, (k == 0) ? CMD_ACTIVE : CMD_RDA);
    end

    // Illegal READ with the bank closed, harmless POWER_D, undefined code.
    reset_bank();
    for (int k = 0; k < 6; k++) begin
      logic [3:0] c;
      c = (k == 0) ? CMD_READ : (k == 2) ? CMD_POWER_D : 4'hC;
      if (k == 1) begin chk("ill_err1", 8'(protocol_err_o), 8'd1); chk("ill_act1", 8'(act_ok_o), 8'd1); chk("ill_st1", 8'(timing_state_o), 8'(CODE_IDLE)); end
      if (k == 2) chk("ill_err2", 8'(protocol_err_o), 8'd0);
      if (k == 3) chk("ill_err3", 8'(protocol_err_o), 8'd0);
      if (k == 4) chk("ill_err4", 8'(protocol_err_o), 8'd1);
      if (k == 5) chk("ill_err5", 8'(protocol_err_o), 8'd0);
      step(1'b0, k == 0 || k == 2 || k == 3, c);
    end

    // REFRESH@0: ACT blocked until 88.
    reset_bank();
    for (int k = 0; k < 90; k++) begin
      if (k == 87) begin chk("ref_act87", 8'(act_ok_o), 8'd0); chk("ref_st87", 8'(timing_state_o), 8'(CODE_PRECHARGE_TO_REFRESH)); end
      if (k == 88) begin chk("ref_act88", 8'(act_ok_o), 8'd1); chk("ref_st88", 8'(timing_state_o), 8'(CODE_IDLE)); end
      step(1'b0, k == 0, CMD_REFRESH);
    end

    // REFRESH@0, reset at 40 together with an otherwise illegal command.
    reset_bank();
    for (int k = 0; k < 42; k++) begin
      if (k == 39) chk("rr_act39", 8'(act_ok_o), 8'd0);
      if (k == 41) begin
        chk("rr_act41", 8'(act_ok_o), 8'd1);
        chk("rr_st41",  8'(timing_state_o), 8'(CODE_IDLE));
        chk("rr_err41", 8'(protocol_err_o), 8'd0);
      end
      step(k == 40, k == 0 || k == 40, CMD_REFRESH);
    end

    // Randomized traffic, mostly legal, checked every cycle.
    for (int i = 0; i < 4000; i++) begin
      int         r;
      bit         rs, v;
      logic [3:0] c;
      r  = $urandom_range(0, 99);
      rs = (r < 2);
      v  = 1'b0;
      c  = CMD_NOP;
      if (!rs && r >= 45) begin
        v = 1'b1;
        if (r >= 90) c = 4'($urandom_range(0, 15));
        else         c = pick_legal();
      end
      step(rs, v, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
